// File: rtl/execute_stage_pkg.sv
// Shared types for the execute stage: opcodes, register/address types,
// the execute-to-store packet and small opcode classification helpers.
package execute_stage_pkg;

    localparam int XLEN        = 64;
    localparam int PHYS_ADDR_W = 21;

    typedef logic [PHYS_ADDR_W-1:0] phys_memory_address_t;
    typedef logic [3:0]             reg_index_t;

    typedef enum logic [4:0] {
        OP_NOP   = 5'd0,
        OP_MOV   = 5'd1,
        OP_ADD   = 5'd2,
        OP_SUB   = 5'd3,
        OP_AND   = 5'd4,
        OP_OR    = 5'd5,
        OP_XOR   = 5'd6,
        OP_SHL   = 5'd7,
        OP_SHR   = 5'd8,
        OP_CMP   = 5'd9,
        OP_MUL   = 5'd10,
        OP_JMP   = 5'd11,
        OP_JEQ   = 5'd12,
        OP_JNE   = 5'd13,
        OP_JLT   = 5'd14,
        OP_LOAD  = 5'd15,
        OP_STORE = 5'd16
    } exec_op_t;

    typedef enum logic {
        MUL_IDLE,
        MUL_RUN
    } mul_state_t;

    // Raw 5-bit opcode is carried so that illegal codes are echoed unchanged.
    typedef struct packed {
        logic [4:0]           opcode;
        reg_index_t           dst_reg;
        logic                 write_reg;
        logic [XLEN-1:0]      value;
        phys_memory_address_t mem_addr;
        logic                 branch_taken;
        phys_memory_address_t branch_target;
        logic                 illegal;
    } ExecuteToStoreBus;

    // Ops whose result lands in the register file.
    function automatic logic op_writes_reg(input logic [4:0] code);
        logic wr;
        case (code)
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SHL, OP_SHR, OP_MUL, OP_LOAD: wr = 1'b1;
            default:                         wr = 1'b0;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode->execute and execute->store valid/ready buses.
interface dec_exec_if
    import execute_stage_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 21
);
    logic              valid;
    logic              ready;
    logic [4:0]        opcode;
    reg_index_t        dst_reg;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] src_c;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;

    modport master (
        output valid, opcode, dst_reg, src_a, src_b, src_c, pc, target,
        input  ready
    );
    modport slave (
        input  valid, opcode, dst_reg, src_a, src_b, src_c, pc, target,
        output ready
    );
endinterface

interface exec_store_if
    import execute_stage_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 21
);
    logic              valid;
    logic              ready;
    logic [4:0]        opcode;
    reg_index_t        dst_reg;
    logic              write_reg;
    logic [DATA_W-1:0] value;
    logic [ADDR_W-1:0] mem_addr;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              illegal;

    modport master (
        output valid, opcode, dst_reg, write_reg, value, mem_addr,
               branch_taken, branch_target, illegal,
        input  ready
    );
    modport slave (
        input  valid, opcode, dst_reg, write_reg, value, mem_addr,
               branch_taken, branch_target, illegal,
        output ready
    );
endinterface

// File: rtl/execute_stage_multiplier.sv
// Iterative shift-and-add multiplier: one DATA_W/MUL_STEPS-bit slice of B per
// cycle. The final step's sum is presented combinationally with done, so the
// caller registers the product on the same edge the FSM returns to idle.
module exec_multiplier
    import execute_stage_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int MUL_STEPS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              abort,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int SLICE_W = DATA_W / MUL_STEPS;
    localparam int STEP_W  = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MUL_STEPS - 1);

    mul_state_t        state_reg, state_next;
    logic [STEP_W-1:0] step_reg, step_next;
    logic [DATA_W-1:0] acc_reg, acc_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic [DATA_W-1:0] b_reg, b_next;
    logic [DATA_W-1:0] partial;

    // A is pre-shifted by one slice per step, so the low slice of the
    // right-shifting B always supplies the current multiplier digit.
    assign partial = a_reg * {{(DATA_W-SLICE_W){1'b0}}, b_reg[SLICE_W-1:0]};
    assign product = acc_reg + partial;
    assign busy    = (state_reg == MUL_RUN);

    // State, step counter and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= MUL_IDLE;
            step_reg  <= '0;
            acc_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            acc_reg   <= acc_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
        end
    end

    // Next-state and step/accumulate logic.
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        acc_next   = acc_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        done       = 1'b0;
        case (state_reg)
            MUL_IDLE: begin
                if (start && !abort) begin
                    state_next = MUL_RUN;
                    step_next  = '0;
                    acc_next   = '0;
                    a_next     = a;
                    b_next     = b;
                end
            end
            MUL_RUN: begin
                if (abort) begin
                    state_next = MUL_IDLE;
                    step_next  = '0;
                end else begin
                    acc_next = acc_reg + partial;
                    a_next   = a_reg << SLICE_W;
                    b_next   = b_reg >> SLICE_W;
                    if (step_reg == LAST_STEP) begin
                        done       = 1'b1;
                        state_next = MUL_IDLE;
                        step_next  = '0;
                    end else begin
                        step_next = step_reg + STEP_W'(1);
                    end
                end
            end
            default: state_next = MUL_IDLE;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// In-order scalar execute stage: ALU, compare/branch resolution, address
// generation and an iterative multiplier feeding one registered result
// packet toward the store stage.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int core_id   = 0,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 21,
    parameter int MUL_STEPS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    dec_exec_if.slave  dec,
    exec_store_if.master st
);
    exec_op_t          op;
    logic              accept;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;
    logic [ADDR_W-1:0] addr_sum;

    ExecuteToStoreBus  st_reg;
    ExecuteToStoreBus  alu_pkt;
    ExecuteToStoreBus  mul_pkt;
    logic              st_valid_reg;
    logic              flag_z_reg;
    logic              flag_n_reg;
    reg_index_t        mul_dst_reg;

    assign op = exec_op_t'(dec.opcode);

    // Nothing enters while the multiplier owns the stage, while a flush is
    // cleaning up, or while the output slot is held by back-pressure.
    assign dec.ready = !flush && !mul_busy && (!st_valid_reg || st.ready);
    assign accept    = dec.valid && dec.ready;
    assign mul_start = accept && (op == OP_MUL);

    // Address generation wraps silently inside the physical address space.
    assign addr_sum = dec.src_a[ADDR_W-1:0] + dec.src_b[ADDR_W-1:0];

    exec_multiplier #(
        .DATA_W    (DATA_W),
        .MUL_STEPS (MUL_STEPS)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .abort   (flush),
        .start   (mul_start),
        .a       (dec.src_a),
        .b       (dec.src_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle result packet for everything except MUL.
    always_comb begin
        alu_pkt           = '0;
        alu_pkt.opcode    = dec.opcode;
        alu_pkt.dst_reg   = dec.dst_reg;
        alu_pkt.write_reg = op_writes_reg(dec.opcode);
        case (op)
            OP_NOP, OP_CMP, OP_MUL: ;
            OP_MOV: alu_pkt.value = dec.src_a;
            OP_ADD: alu_pkt.value = dec.src_a + dec.src_b;
            OP_SUB: alu_pkt.value = dec.src_a - dec.src_b;
            OP_AND: alu_pkt.value = dec.src_a & dec.src_b;
            OP_OR:  alu_pkt.value = dec.src_a | dec.src_b;
            OP_XOR: alu_pkt.value = dec.src_a ^ dec.src_b;
            OP_SHL: alu_pkt.value = dec.src_a << dec.src_b[5:0];
            OP_SHR: alu_pkt.value = dec.src_a >> dec.src_b[5:0];
            OP_JMP: begin
                alu_pkt.branch_taken  = 1'b1;
                alu_pkt.branch_target = dec.target;
            end
            OP_JEQ: begin
                alu_pkt.branch_taken  = flag_z_reg;
                alu_pkt.branch_target = dec.target;
            end
            OP_JNE: begin
                alu_pkt.branch_taken  = !flag_z_reg;
                alu_pkt.branch_target = dec.target;
            end
            OP_JLT: begin
                alu_pkt.branch_taken  = flag_n_reg;
                alu_pkt.branch_target = dec.target;
            end
            OP_LOAD: alu_pkt.mem_addr = addr_sum;
            OP_STORE: begin
                alu_pkt.mem_addr = addr_sum;
                alu_pkt.value    = dec.src_c;
            end
            default: alu_pkt.illegal = 1'b1;
        endcase
    end

    // Packet produced when the multiplier finishes.
    always_comb begin
        mul_pkt           = '0;
        mul_pkt.opcode    = OP_MUL;
        mul_pkt.dst_reg   = mul_dst_reg;
        mul_pkt.write_reg = 1'b1;
        mul_pkt.value     = mul_product;
    end

    // Condition flags change only when a CMP is accepted; flush keeps them.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_z_reg <= 1'b0;
            flag_n_reg <= 1'b0;
        end else if (accept && (op == OP_CMP)) begin
            flag_z_reg <= (dec.src_a == dec.src_b);
            flag_n_reg <= ($signed(dec.src_a) < $signed(dec.src_b));
        end
    end

    // Destination of the multiply in flight, echoed when it completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_dst_reg <= '0;
        end else if (mul_start) begin
            mul_dst_reg <= dec.dst_reg;
        end
    end

    // Output slot: load, hold under back-pressure, clear on handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_valid_reg <= 1'b0;
            st_reg       <= '0;
        end else if (flush) begin
            st_valid_reg <= 1'b0;
        end else if (accept && (op != OP_MUL)) begin
            st_valid_reg <= 1'b1;
            st_reg       <= alu_pkt;
        end else if (mul_done) begin
            st_valid_reg <= 1'b1;
            st_reg       <= mul_pkt;
        end else if (st_valid_reg && st.ready) begin
            st_valid_reg <= 1'b0;
            st_reg       <= '0;
        end
    end

    assign st.valid         = st_valid_reg;
    assign st.opcode        = st_reg.opcode;
    assign st.dst_reg       = st_reg.dst_reg;
    assign st.write_reg     = st_reg.write_reg;
    assign st.value         = st_reg.value;
    assign st.mem_addr      = st_reg.mem_addr;
    assign st.branch_taken  = st_reg.branch_taken;
    assign st.branch_target = st_reg.branch_target;
    assign st.illegal       = st_reg.illegal;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- In-order scalar execute stage; sits directly downstream of the decode stage.
- Consumes resolved-operand packets from the decode→execute bus.
- Performs ALU, multiply, compare/branch and load/store address generation.
- Emits one registered result packet per instruction toward the store stage, which forwards branch redirects to fetch.

Parameters:
core_id, 0, core index, used only in simulation $display tracing
DATA_W, 64, operand/result width
ADDR_W, 21, physical address width (matches phys_memory_address_t)
MUL_STEPS, 4, iterative-multiply steps (each consumes DATA_W/MUL_STEPS multiplier bits)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high
flush  in  1  drop in-flight/held work (store-side redirect)
dec_valid  in  1  decode packet present
dec_ready  out  1  execute can accept this cycle
dec_opcode  in  5  exec_op_t
dec_dst_reg  in  4  destination register index
dec_src_a  in  DATA_W  operand A / base address
dec_src_b  in  DATA_W  operand B / offset / shift amount
dec_src_c  in  DATA_W  store data
dec_pc  in  ADDR_W  instruction address
dec_target  in  ADDR_W  branch/jump target
st_valid  out  1  result packet present
st_ready  in  1  store stage accepts
st_opcode  out  5  echoed opcode
st_dst_reg  out  4  echoed destination
st_write_reg  out  1  result must be written to reg_file
st_value  out  DATA_W  ALU result or store data
st_mem_addr  out  ADDR_W  load/store address
st_branch_taken  out  1  redirect required
st_branch_target  out  ADDR_W  redirect address
st_illegal  out  1  unknown opcode

Behaviour:
- Reset: st_valid=0, all st_* data=0, flags Z=N=0, multiplier idle, dec_ready=1 on the cycle after reset deasserts. Reset mid-MUL aborts it with no output.
- Accept when dec_valid && dec_ready.
- dec_ready = !mul_busy && (!st_valid || st_ready).
- Output is registered. It holds stable while st_valid && !st_ready. It is cleared on the handshake unless a new packet is loaded the same cycle.
- Single-cycle ops: accepted at edge N → st_valid=1 after edge N.
- Ops: NOP0, MOV1 (A), ADD2, SUB3, AND4, OR5, XOR6, SHL7, SHR8.
  - SHL/SHR: logical shift, amount = B[5:0].
  - Arithmetic wraps mod 2^64.
- CMP9:
  - Z = (A==B); N = signed(A)<signed(B).
  - Flags update at accept, so the next accepted op sees them (CMP→JEQ back-to-back valid).
  - st_write_reg=0.
- MUL10: low 64 bits of A*B.
  - FSM IDLE→MUL(step 0..MUL_STEPS-1)→IDLE.
  - Each step adds (A × 16-bit slice of B) << 16*step to an accumulator.
  - Result registered after MUL_STEPS edges following accept; st_valid at N+MUL_STEPS.
  - dec_ready=0 throughout.
- Branches:
  - JMP11 taken always; JEQ12 if Z; JNE13 if !Z; JLT14 if N.
  - st_branch_target = dec_target; st_write_reg=0.
  - Not-taken branches still produce a packet with st_branch_taken=0.
- LOAD15: st_mem_addr=(A+B)[ADDR_W-1:0]; st_write_reg=1.
- STORE16: st_mem_addr=(A+B)[ADDR_W-1:0]; st_value=C; st_write_reg=0.
- Address add truncates silently.
- st_write_reg=1 for MOV..SHR, MUL and LOAD; 0 otherwise.
- Opcode >16: st_illegal=1, st_write_reg=0, st_branch_taken=0, flags unchanged.
- flush (priority over everything except reset):
  - Clears st_valid and aborts the MUL FSM to IDLE.
  - Any dec_valid in the same cycle is NOT accepted (dec_ready forced 0).
  - Flags preserved.
- Simultaneous st handshake + new accept: new packet replaces the old one, no bubble.

Decomposition:
- Shared package (extend Defines.sv): exec_op_t enum (codes above), reg_index_t (4-bit), phys_memory_address_t reuse, ExecuteToStoreBus packet struct.
- One sub-module: exec_multiplier (iterative FSM, start/busy/done, operands in, 64-bit product out).
- All other logic inline.

Test Plan:
- ADD A=0xFFFF_FFFF_FFFF_FFFF, B=2 → st_value=1, st_write_reg=1, st_valid one edge after accept.
- CMP A=-1, B=1, then JLT target=0x100 back-to-back → N=1, Z=0; JLT st_branch_taken=1, st_branch_target=0x100.
- MUL A=0x1_0000_0001, B=0x3 → st_value=0x3_0000_0003 exactly 4 edges after accept; dec_ready=0 for those 4 cycles.
- Back-pressure: st_ready=0 for 3 cycles after SUB 10-3 → st_value=7 held stable, dec_ready=0; releases on st_ready=1 with the next packet loaded the same edge.
- STORE A=0x1F_FFF0, B=0x20, C=0xAB → st_mem_addr=0x00_0010 (21-bit wrap), st_value=0xAB, st_write_reg=0.
- flush at MUL step 2, then reset mid-packet → no output from the aborted MUL; after reset st_valid=0, flags 0, dec_ready=1; opcode 0x1F → st_illegal=1.
